alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Multicycle issue/control FSM that sits upstream of the 32-bit ALU in the CPU54 datapath.
- Accepts one decoded-format MIPS ALU-class instruction per valid/ready handshake and drives the ALU's 4-bit ALUC code and operand selects.
- Consumes the ALU's ZERO/CARRY/NEGATIVE/OVERFLOW flags to produce register-file write control, SLT bit, branch decision and overflow trap.
- It is the producer end of the ALUC/flag interface.

Parameters:
- RESET_ALUC, 4'b0000, ALUC value driven while idle and in reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr  in  32  MIPS instruction word.
- instr_ready  out  1  controller can accept; high only in IDLE.
- ALUC  out  4  ALU operation code.
- a_sel  out  1  0 = rs, 1 = zero-extended shamt (instr[10:6]).
- b_sel  out  2  0 = rt, 1 = sign-extended imm16, 2 = zero-extended imm16.
- ZERO, CARRY, NEGATIVE, OVERFLOW  in  1 each  ALU flags.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  5  destination: rd for R-type, rt for I-type.
- res_sel  out  1  0 = ALU RESULT, 1 = {31'b0, flag_bit}.
- flag_bit  out  1  registered SLT outcome.
- branch_taken  out  1  one-cycle pulse, BEQ/BNE resolved taken.
- ovf_trap  out  1  one-cycle pulse, signed overflow.
- illegal  out  1  one-cycle pulse, unsupported encoding.

Behaviour:
- Reset: state=IDLE; ALUC=RESET_ALUC; all other outputs 0, except instr_ready=1. rst wins over everything; mid-operation rst aborts the op, producing no write and no pulse.
- States and transitions:
  - IDLE -> EXEC on instr_valid&instr_ready. instr is registered; decode is performed from the registered copy.
  - EXEC (1 cycle): ALUC/a_sel/b_sel driven from decode; flags sampled at the end of EXEC. Next state is WB, TRAP or IDLE per the rules below.
  - WB (1 cycle): rf_we=1, rf_waddr, res_sel held. Next IDLE.
  - TRAP (1 cycle): ovf_trap=1, rf_we=0. Next IDLE.
- Latency: accept at cycle 0, EXEC at cycle 1, WB/TRAP/pulse at cycle 2, instr_ready high again at cycle 3. Throughput is 1 instruction per 3 cycles.
- ALUC encoding (fixed):
  - ADDU/ADDIU 0000; SUBU 0001; ADD/ADDI 0010; SUB 0011.
  - AND/ANDI 0100; OR/ORI 0101; XOR/XORI 0110; NOR 0111.
  - LUI 1000; SLTU/SLTIU 1010; SLT/SLTI 1011.
  - SRA/SRAV 1100; SRL/SRLV 1101; SLL/SLLV 1111.
  - BEQ/BNE 0011.
- Operand selects:
  - Shift-immediate forms: a_sel=1.
  - Logical immediates (ANDI/ORI/XORI) and LUI: b_sel=2.
  - Arithmetic/SLT immediates: b_sel=1.
  - Everything else: b_sel=0.
- OVERFLOW is only meaningful when ALUC[3:1]=001; CARRY only for 1010 or 0000/0001/11xx. The controller samples a flag only in EXEC for an op where that flag is valid and never relies on the ALU's held value.
- ADD/ADDI/SUB with OVERFLOW=1 -> TRAP; otherwise WB. ADDU/ADDIU/SUBU never trap.
- SLT/SLTI: flag_bit=NEGATIVE, res_sel=1. SLTU/SLTIU: flag_bit=CARRY, res_sel=1. All other ops: res_sel=0.
- BEQ: branch_taken=ZERO. BNE: branch_taken=~ZERO. The pulse occurs in the cycle after EXEC; branches have no rf_we (EXEC -> IDLE via a 1-cycle pulse slot, i.e. the same 3-cycle cadence).
- Destination register 0: write strobe is still issued; the register file discards it.
- Unsupported opcode/funct: illegal pulses at cycle 2, no write, no ALU-dependent output.
- instr_valid while not ready is ignored and must be held by the source.

Test Plan:
- ADDU rd=3 (rs=0x7FFFFFFF, rt=1 via bench ALU model): ALUC=0000 at cycle 1, rf_we=1 and rf_waddr=3 at cycle 2, no trap.
- ADD same operands (OVERFLOW=1): ALUC=0010, ovf_trap pulse at cycle 2, rf_we stays 0, instr_ready=1 at cycle 3.
- SLTIU rt=5 imm=0xFFFF with rs=1: b_sel=1, ALUC=1010, CARRY=1 -> flag_bit=1, res_sel=1, rf_waddr=5.
- BEQ with ZERO=1 then BNE with ZERO=1: branch_taken=1, then 0; rf_we never asserted.
- SLL shamt=4 then LUI imm=0x1234: a_sel=1, ALUC=1111; then b_sel=2, ALUC=1000.
- rst asserted during EXEC of ADD: next cycle state IDLE, ALUC=0000, no rf_we/ovf_trap; instr_valid held high during busy cycles is not re-accepted twice.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multicycle issue/control FSM sitting upstream of the 32-bit ALU.
// Accepts one MIPS ALU-class instruction per handshake, drives ALUC and operand
// selects during EXEC, then turns the sampled ALU flags into a register-file
// write, an overflow trap, a branch decision or an illegal-encoding pulse.
module alu_issue_ctrl #(
    parameter logic [3:0] RESET_ALUC = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  ALUC,
    output logic        a_sel,
    output logic [1:0]  b_sel,
    input  logic        ZERO,
    input  logic        CARRY,
    input  logic        NEGATIVE,
    input  logic        OVERFLOW,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic        res_sel,
    output logic        flag_bit,
    output logic        branch_taken,
    output logic        ovf_trap,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WB,
        S_TRAP,
        S_PULSE
    } state_t;

    // How the result of an instruction is retired once the flags are known.
    typedef enum logic [2:0] {
        OP_ILLEGAL,
        OP_PLAIN,
        OP_OVF,
        OP_SLT,
        OP_SLTU,
        OP_BEQ,
        OP_BNE
    } op_class_t;

    state_t      state_q, state_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [5:0]  funct_q, funct_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  rd_q, rd_d;
    logic        flag_q, flag_d;
    logic        taken_q, taken_d;

    logic [3:0]  dec_aluc;
    logic        dec_a_sel;
    logic [1:0]  dec_b_sel;
    op_class_t   dec_class;
    logic [4:0]  dec_waddr;

    logic        accept;

    // rs, shamt and the immediate feed the ALU operand path directly, never this controller.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

    assign accept = instr_valid && (state_q == S_IDLE);

    // State and captured-instruction registers; synchronous reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            funct_q  <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            flag_q   <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            flag_q   <= flag_d;
            taken_q  <= taken_d;
        end
    end

    // Decode of the registered instruction into ALU controls and retire class.
    always_comb begin
        dec_aluc  = RESET_ALUC;
        dec_a_sel = 1'b0;
        dec_b_sel = 2'd0;
        dec_class = OP_ILLEGAL;
        dec_waddr = rt_q;
        if (opcode_q == 6'h00) begin
            dec_waddr = rd_q;
            dec_class = OP_PLAIN;
            case (funct_q)
                6'h00: begin dec_aluc = 4'b1111; dec_a_sel = 1'b1; end  // SLL
                6'h02: begin dec_aluc = 4'b1101; dec_a_sel = 1'b1; end  // SRL
                6'h03: begin dec_aluc = 4'b1100; dec_a_sel = 1'b1; end  // SRA
                6'h04: dec_aluc = 4'b1111;                              // SLLV
                6'h06: dec_aluc = 4'b1101;                              // SRLV
                6'h07: dec_aluc = 4'b1100;                              // SRAV
                6'h20: begin dec_aluc = 4'b0010; dec_class = OP_OVF; end // ADD
                6'h21: dec_aluc = 4'b0000;                              // ADDU
                6'h22: begin dec_aluc = 4'b0011; dec_class = OP_OVF; end // SUB
                6'h23: dec_aluc = 4'b0001;                              // SUBU
                6'h24: dec_aluc = 4'b0100;                              // AND
                6'h25: dec_aluc = 4'b0101;                              // OR
                6'h26: dec_aluc = 4'b0110;                              // XOR
                6'h27: dec_aluc = 4'b0111;                              // NOR
                6'h2A: begin dec_aluc = 4'b1011; dec_class = OP_SLT;  end // SLT
                6'h2B: begin dec_aluc = 4'b1010; dec_class = OP_SLTU; end // SLTU
                default: begin
                    dec_aluc  = RESET_ALUC;
                    dec_class = OP_ILLEGAL;
                end
            endcase
        end else begin
            case (opcode_q)
                6'h04: begin dec_aluc = 4'b0011; dec_class = OP_BEQ; end
                6'h05: begin dec_aluc = 4'b0011; dec_class = OP_BNE; end
                6'h08: begin dec_aluc = 4'b0010; dec_b_sel = 2'd1; dec_class = OP_OVF;   end // ADDI
                6'h09: begin dec_aluc = 4'b0000; dec_b_sel = 2'd1; dec_class = OP_PLAIN; end // ADDIU
                6'h0A: begin dec_aluc = 4'b1011; dec_b_sel = 2'd1; dec_class = OP_SLT;   end // SLTI
                6'h0B: begin dec_aluc = 4'b1010; dec_b_sel = 2'd1; dec_class = OP_SLTU;  end // SLTIU
                6'h0C: begin dec_aluc = 4'b0100; dec_b_sel = 2'd2; dec_class = OP_PLAIN; end // ANDI
                6'h0D: begin dec_aluc = 4'b0101; dec_b_sel = 2'd2; dec_class = OP_PLAIN; end // ORI
                6'h0E: begin dec_aluc = 4'b0110; dec_b_sel = 2'd2; dec_class = OP_PLAIN; end // XORI
                6'h0F: begin dec_aluc = 4'b1000; dec_b_sel = 2'd2; dec_class = OP_PLAIN; end // LUI
                default: dec_class = OP_ILLEGAL;
            endcase
        end
    end

    // Next-state logic: capture on accept, sample only the flags valid for the op in EXEC.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        funct_d  = funct_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        flag_d   = flag_q;
        taken_d  = taken_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    opcode_d = instr[31:26];
                    funct_d  = instr[5:0];
                    rt_d     = instr[20:16];
                    rd_d     = instr[15:11];
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                flag_d  = 1'b0;
                taken_d = 1'b0;
                case (dec_class)
                    OP_SLT:  flag_d  = NEGATIVE;
                    OP_SLTU: flag_d  = CARRY;
                    OP_BEQ:  taken_d = ZERO;
                    OP_BNE:  taken_d = ~ZERO;
                    default: ;
                endcase
                // Branches and illegal encodings still occupy a slot so the cadence stays at 3 cycles.
                case (dec_class)
                    OP_ILLEGAL, OP_BEQ, OP_BNE: state_d = S_PULSE;
                    OP_OVF:  state_d = OVERFLOW ? S_TRAP : S_WB;
                    default: state_d = S_WB;
                endcase
            end
            S_WB:    state_d = S_IDLE;
            S_TRAP:  state_d = S_IDLE;
            S_PULSE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state and the registered instruction.
    always_comb begin
        instr_ready  = 1'b0;
        ALUC         = RESET_ALUC;
        a_sel        = 1'b0;
        b_sel        = 2'd0;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        res_sel      = 1'b0;
        branch_taken = 1'b0;
        ovf_trap     = 1'b0;
        illegal      = 1'b0;
        flag_bit     = flag_q;
        case (state_q)
            S_IDLE: instr_ready = 1'b1;
            S_EXEC: begin
                ALUC  = dec_aluc;
                a_sel = dec_a_sel;
                b_sel = dec_b_sel;
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = dec_waddr;
                res_sel  = (dec_class == OP_SLT) || (dec_class == OP_SLTU);
            end
            S_TRAP: ovf_trap = 1'b1;
            S_PULSE: begin
                branch_taken = taken_q;
                illegal      = (dec_class == OP_ILLEGAL);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a behavioural ALU drives the flags from the
// controller's ALUC/selects; expected controller behaviour comes from a table of
// hand-derived vectors and an instruction-level reference model for random ops.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [3:0] aluc;
        logic       a_sel;
        logic [1:0] b_sel;
        logic       we;
        logic [4:0] waddr;
        logic       res;
        logic       flag;
        logic       br;
        logic       trap;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  ALUC;
    logic        a_sel;
    logic [1:0]  b_sel;
    logic        ZERO, CARRY, NEGATIVE, OVERFLOW;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        res_sel, flag_bit, branch_taken, ovf_trap, illegal;

    logic [31:0] rs_v, rt_v;
    logic [31:0] cur_ins;
    int          errors = 0;
    int          checks = 0;

    alu_issue_ctrl #(.RESET_ALUC(4'b0000)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .ALUC(ALUC), .a_sel(a_sel), .b_sel(b_sel),
        .ZERO(ZERO), .CARRY(CARRY), .NEGATIVE(NEGATIVE), .OVERFLOW(OVERFLOW),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .res_sel(res_sel), .flag_bit(flag_bit),
        .branch_taken(branch_taken), .ovf_trap(ovf_trap), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Behavioural 32-bit ALU: flags follow the ALUC code and operand selects driven by the DUT.
    logic [31:0] alu_a, alu_b, alu_r;
    logic [32:0] alu_w;
    logic        alu_c, alu_v, alu_lt;
    always_comb begin
        alu_a = a_sel ? {27'd0, instr[10:6]} : rs_v;
        case (b_sel)
            2'd1:    alu_b = {{16{instr[15]}}, instr[15:0]};
            2'd2:    alu_b = {16'd0, instr[15:0]};
            default: alu_b = rt_v;
        endcase
        alu_w  = 33'd0;
        alu_r  = 32'd0;
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        alu_lt = 1'b0;
        case (ALUC)
            4'b0000, 4'b0010: begin
                alu_w = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r = alu_w[31:0];
                alu_c = alu_w[32];
                alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'b0001, 4'b0011: begin
                alu_r = alu_a - alu_b;
                alu_c = alu_a < alu_b;
                alu_v = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'b0100: alu_r = alu_a & alu_b;
            4'b0101: alu_r = alu_a | alu_b;
            4'b0110: alu_r = alu_a ^ alu_b;
            4'b0111: alu_r = ~(alu_a | alu_b);
            4'b1000: alu_r = {alu_b[15:0], 16'd0};
            4'b1010: begin alu_c = alu_a < alu_b; alu_r = {31'd0, alu_c}; end
            4'b1011: begin alu_lt = $signed(alu_a) < $signed(alu_b); alu_r = {31'd0, alu_lt}; end
            4'b1100: alu_r = $signed(alu_b) >>> alu_a[4:0];
            4'b1101: alu_r = alu_b >> alu_a[4:0];
            4'b1111: alu_r = alu_b << alu_a[4:0];
            default: alu_r = 32'd0;
        endcase
        ZERO     = (alu_r == 32'd0);
        CARRY    = alu_c;
        NEGATIVE = (ALUC == 4'b1011) ? alu_lt : alu_r[31];
        OVERFLOW = alu_v;
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t mk(input logic [3:0] aluc, input logic as, input logic [1:0] bs,
                                input logic we, input logic [4:0] wa, input logic res,
                                input logic flag, input logic br, input logic trap, input logic ill);
        exp_t e;
        e = '{aluc: aluc, a_sel: as, b_sel: bs, we: we, waddr: wa, res: res,
              flag: flag, br: br, trap: trap, ill: ill};
        return e;
    endfunction

    // Instruction-level reference: architectural meaning of each instruction computed
    // directly from the operand values with wide signed/unsigned arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] si, zi;
        longint      sa, sb, sum;
        e  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        si = {{16{ins[15]}}, ins[15:0]};
        zi = {16'd0, ins[15:0]};
        sa = longint'($signed(a));
        if (op == 6'h00) begin
            e.we    = 1'b1;
            e.waddr = ins[15:11];
            sb      = longint'($signed(b));
            case (fn)
                6'h00: begin e.aluc = 4'b1111; e.a_sel = 1'b1; end
                6'h02: begin e.aluc = 4'b1101; e.a_sel = 1'b1; end
                6'h03: begin e.aluc = 4'b1100; e.a_sel = 1'b1; end
                6'h04: e.aluc = 4'b1111;
                6'h06: e.aluc = 4'b1101;
                6'h07: e.aluc = 4'b1100;
                6'h20, 6'h22: begin
                    e.aluc = (fn == 6'h20) ? 4'b0010 : 4'b0011;
                    sum    = (fn == 6'h20) ? sa + sb : sa - sb;
                    if (sum > 64'sd2147483647 || sum < -64'sd2147483648) begin
                        e.we = 1'b0; e.waddr = 5'd0; e.trap = 1'b1;
                    end
                end
                6'h21: e.aluc = 4'b0000;
                6'h23: e.aluc = 4'b0001;
                6'h24: e.aluc = 4'b0100;
                6'h25: e.aluc = 4'b0101;
                6'h26: e.aluc = 4'b0110;
                6'h27: e.aluc = 4'b0111;
                6'h2A: begin e.aluc = 4'b1011; e.res = 1'b1; e.flag = (sa < sb); end
                6'h2B: begin e.aluc = 4'b1010; e.res = 1'b1; e.flag = (a < b); end
                default: begin e = '0; e.ill = 1'b1; end
            endcase
        end else begin
            e.we    = 1'b1;
            e.waddr = ins[20:16];
            sb      = longint'($signed(si));
            case (op)
                6'h04, 6'h05: begin
                    e.we = 1'b0; e.waddr = 5'd0; e.aluc = 4'b0011;
                    e.br = (op == 6'h04) ? (a == b) : (a != b);
                end
                6'h08: begin
                    e.aluc = 4'b0010; e.b_sel = 2'd1;
                    sum = sa + sb;
                    if (sum > 64'sd2147483647 || sum < -64'sd2147483648) begin
                        e.we = 1'b0; e.waddr = 5'd0; e.trap = 1'b1;
                    end
                end
                6'h09: begin e.aluc = 4'b0000; e.b_sel = 2'd1; end
                6'h0A: begin e.aluc = 4'b1011; e.b_sel = 2'd1; e.res = 1'b1; e.flag = (sa < sb); end
                6'h0B: begin e.aluc = 4'b1010; e.b_sel = 2'd1; e.res = 1'b1; e.flag = (a < si); end
                6'h0C: begin e.aluc = 4'b0100; e.b_sel = 2'd2; end
                6'h0D: begin e.aluc = 4'b0101; e.b_sel = 2'd2; end
                6'h0E: begin e.aluc = 4'b0110; e.b_sel = 2'd2; end
                6'h0F: begin e.aluc = 4'b1000; e.b_sel = 2'd2; if (zi == 32'd0) e.aluc = 4'b1000; end
                default: begin e = '0; e.ill = 1'b1; end
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s instr=%h: got %0h expected %0h", nm, cur_ins, act, expv);
        end
    endtask

    // Issue one instruction and check its EXEC cycle, retire cycle and return to IDLE.
    task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int unsigned w;
        w = 0;
        @(negedge clk);
        while (!instr_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        cur_ins = ins;
        chk("ready_before_issue", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = ins;
        rs_v        = a;
        rt_v        = b;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("c1_ready", 32'(instr_ready), 32'd0);
        chk("c1_aluc",  32'(ALUC),        32'(e.aluc));
        chk("c1_a_sel", 32'(a_sel),       32'(e.a_sel));
        chk("c1_b_sel", 32'(b_sel),       32'(e.b_sel));
        chk("c1_rf_we", 32'(rf_we),       32'd0);
        @(posedge clk); #1;
        chk("c2_rf_we",    32'(rf_we),        32'(e.we));
        chk("c2_waddr",    32'(rf_waddr),     32'(e.waddr));
        chk("c2_res_sel",  32'(res_sel),      32'(e.res));
        chk("c2_flag_bit", 32'(flag_bit),     32'(e.flag));
        chk("c2_branch",   32'(branch_taken), 32'(e.br));
        chk("c2_ovf_trap", 32'(ovf_trap),     32'(e.trap));
        chk("c2_illegal",  32'(illegal),      32'(e.ill));
        chk("c2_ready",    32'(instr_ready),  32'd0);
        @(posedge clk); #1;
        chk("c3_ready",    32'(instr_ready),  32'd1);
        chk("c3_rf_we",    32'(rf_we),        32'd0);
        chk("c3_ovf_trap", 32'(ovf_trap),     32'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  fn;
        logic [5:0]  op;
        logic [5:0]  rfn[18];
        logic [5:0]  iop[13];
        rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h18};
        iop = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                6'h0F, 6'h23, 6'h2B, 6'h02};
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        sh  = 5'($urandom);
        case ($urandom_range(0, 3))
            0:       imm = 16'hFFFF;
            1:       imm = 16'h7FFF;
            default: imm = 16'($urandom);
        endcase
        if ($urandom_range(0, 1) == 0) begin
            fn = rfn[$urandom_range(0, 17)];
            return rtype(rs, rt, rd, sh, fn);
        end
        op = iop[$urandom_range(0, 12)];
        return itype(op, rs, rt, imm);
    endfunction

    vec_t tbl[15];

    initial begin
        logic [31:0] ins, a, b;
        int          trap_seen;

        tbl[0]  = '{rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'h7FFF_FFFF, 32'd1,
                    mk(4'b0000, 1'b0, 2'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[1]  = '{rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h7FFF_FFFF, 32'd1,
                    mk(4'b0010, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
        tbl[2]  = '{itype(6'h0B, 5'd1, 5'd5, 16'hFFFF), 32'd1, 32'd0,
                    mk(4'b1010, 1'b0, 2'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[3]  = '{itype(6'h04, 5'd1, 5'd2, 16'h0010), 32'd5, 32'd5,
                    mk(4'b0011, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[4]  = '{itype(6'h05, 5'd1, 5'd2, 16'h0010), 32'd5, 32'd5,
                    mk(4'b0011, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[5]  = '{rtype(5'd0, 5'd2, 5'd4, 5'd4, 6'h00), 32'd0, 32'd1,
                    mk(4'b1111, 1'b1, 2'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[6]  = '{itype(6'h0F, 5'd0, 5'd7, 16'h1234), 32'd0, 32'd0,
                    mk(4'b1000, 1'b0, 2'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[7]  = '{rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1,
                    mk(4'b1011, 1'b0, 2'd0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[8]  = '{itype(6'h23, 5'd1, 5'd2, 16'h0004), 32'd0, 32'd0,
                    mk(4'b0000, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[9]  = '{rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h23), 32'h8000_0000, 32'd1,
                    mk(4'b0001, 1'b0, 2'd0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[10] = '{rtype(5'd1, 5'd2, 5'd12, 5'd0, 6'h22), 32'h8000_0000, 32'd1,
                    mk(4'b0011, 1'b0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
        tbl[11] = '{itype(6'h08, 5'd1, 5'd6, 16'h0001), 32'h7FFF_FFFF, 32'd0,
                    mk(4'b0010, 1'b0, 2'd1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)};
        tbl[12] = '{itype(6'h0E, 5'd3, 5'd8, 16'hF0F0), 32'h1234_5678, 32'd0,
                    mk(4'b0110, 1'b0, 2'd2, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[13] = '{rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h07), 32'd3, 32'h8000_0000,
                    mk(4'b1100, 1'b0, 2'd0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tbl[14] = '{rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h21), 32'd4, 32'd4,
                    mk(4'b0000, 1'b0, 2'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        rs_v        = 32'd0;
        rt_v        = 32'd0;
        cur_ins     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   32'(instr_ready),  32'd1);
        chk("rst_aluc",    32'(ALUC),         32'd0);
        chk("rst_rf_we",   32'(rf_we),        32'd0);
        chk("rst_flag",    32'(flag_bit),     32'd0);
        chk("rst_pulses",  32'({branch_taken, ovf_trap, illegal, res_sel, a_sel, b_sel}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            run_op(tbl[i].ins, tbl[i].a, tbl[i].b, tbl[i].e);

        // Reset during EXEC of an overflowing ADD, with instr_valid held high throughout.
        @(negedge clk);
        ins         = rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h20);
        cur_ins     = ins;
        instr       = ins;
        rs_v        = 32'h7FFF_FFFF;
        rt_v        = 32'd1;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        chk("abort_exec_aluc", 32'(ALUC), 32'b0010);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_aluc",  32'(ALUC),        32'd0);
        chk("abort_we",    32'(rf_we),       32'd0);
        chk("abort_trap",  32'(ovf_trap),    32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("held_exec_ready", 32'(instr_ready), 32'd0);
        chk("held_exec_aluc",  32'(ALUC),        32'b0010);
        @(posedge clk); #1;
        chk("held_trap",       32'(ovf_trap),    32'd1);
        chk("held_trap_we",    32'(rf_we),       32'd0);
        instr_valid = 1'b0;
        trap_seen   = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (ovf_trap || rf_we || !instr_ready) trap_seen++;
        end
        chk("held_no_reaccept", 32'(trap_seen), 32'd0);

        // Randomised instructions checked against the reference model.
        for (int n = 0; n < 200; n++) begin
            ins = rand_instr();
            a   = pick_val();
            b   = ($urandom_range(0, 2) == 0) ? a : pick_val();
            run_op(ins, a, b, model(ins, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
